// File: rtl/lite16_alu_pkg.sv
// lite16_alu_pkg: shared op codes, FSM states and flag indices for alu_mc
package lite16_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_OR = 4'h1, OP_XOR = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4, OP_SHR = 4'h5, OP_SAR = 4'h6, OP_SUB = 4'h7;
  localparam logic [3:0] OP_MUL_LO = 4'h8, OP_MUL_HI = 4'h9, OP_DIVU = 4'hA, OP_REMU = 4'hB;
  localparam logic [3:0] OP_CMP_EQ = 4'hC, OP_CMP_LTU = 4'hD, OP_CMP_GTU = 4'hE, OP_CMP_ALW = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  localparam int F_Z = 0, F_N = 1, F_C = 2, F_V = 3, F_DZ = 4;
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative shift-add multiplier / restoring divider, one step per cycle
module alu_mc_iter #(parameter int WIDTH = 16) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem
);
  localparam int SHW = $clog2(WIDTH);
  logic busy, is_div;
  logic [SHW-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] q, d;
  logic [WIDTH:0] sum, sh, diff;
  // prod/quo/rem are the post-step values so the top can latch the final step directly
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
    sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff = sh - {1'b0, d};
    prod = {sum, acc[WIDTH-1:1]};
    quo = {q[WIDTH-2:0], ~diff[WIDTH]};
    rem = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    done = busy && cnt == SHW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      is_div <= 1'b0;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      d <= '0;
    end else if (start) begin
      busy <= 1'b1;
      is_div <= div;
      cnt <= '0;
      acc <= div ? '0 : {{WIDTH{1'b0}}, a};
      q <= a;
      d <= b;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt + 1'b1;
      acc <= is_div ? {{WIDTH{1'b0}}, rem} : prod;
      q <= quo;
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered result/flags
module alu_mc
  import lite16_alu_pkg::*;
#(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);
  localparam int SHW = $clog2(WIDTH);
  state_e state, state_n;
  logic take, iter_op, done, big, bz_q;
  logic [3:0] op_q;
  logic [SHW-1:0] sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, res, res_it, res_n;
  logic [WIDTH:0] add_s, sub_s;
  logic [4:0] flags, fl_n;
  assign in_ready = state == S_IDLE || (state == S_DONE && out_ready);
  assign take = in_valid && in_ready;
  assign iter_op = op[3:2] == 2'b10;
  assign out_valid = state == S_DONE;
  assign flag_z = flags[F_Z];
  assign flag_n = flags[F_N];
  assign flag_c = flags[F_C];
  assign flag_v = flags[F_V];
  assign flag_dz = flags[F_DZ];
  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst_n(rst_n), .start(take && iter_op), .div(op[1]), .a(a), .b(b),
    .done(done), .prod(prod), .quo(quo), .rem(rem)
  );
  always_comb begin
    sh = b[SHW-1:0];
    big = |b[WIDTH-1:SHW];
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    case (op)
      OP_ADD:     res = add_s[WIDTH-1:0];
      OP_OR:      res = a | b;
      OP_XOR:     res = a ^ b;
      OP_AND:     res = a & b;
      OP_SHL:     res = big ? '0 : a << sh;
      OP_SHR:     res = big ? '0 : a >> sh;
      OP_SAR:     res = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> sh);
      OP_SUB:     res = sub_s[WIDTH-1:0];
      OP_CMP_EQ:  res = WIDTH'(a == b);
      OP_CMP_LTU: res = WIDTH'(sub_s[WIDTH]);
      OP_CMP_GTU: res = WIDTH'(a > b);
      OP_CMP_ALW: res = WIDTH'(1);
      default:    res = '0;
    endcase
    res_it = op_q == OP_MUL_LO ? prod[WIDTH-1:0] : op_q == OP_MUL_HI ? prod[2*WIDTH-1:WIDTH] :
             op_q == OP_DIVU ? quo : rem;
    res_n = done ? res_it : res;
    fl_n = '0;
    fl_n[F_Z] = res_n == '0;
    fl_n[F_N] = res_n[WIDTH-1];
    fl_n[F_C] = !done && (op == OP_ADD ? add_s[WIDTH] : op == OP_SUB && sub_s[WIDTH]);
    fl_n[F_V] = !done && (op == OP_ADD ? a[WIDTH-1] == b[WIDTH-1] && res_n[WIDTH-1] != a[WIDTH-1] :
                op == OP_SUB && a[WIDTH-1] != b[WIDTH-1] && res_n[WIDTH-1] != a[WIDTH-1]);
    fl_n[F_DZ] = done && op_q[3:1] == 3'b101 && bz_q;
    state_n = take ? (iter_op ? S_BUSY : S_DONE) :
              state == S_BUSY ? (done ? S_DONE : S_BUSY) :
              state == S_DONE && out_ready ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= '0;
      bz_q <= 1'b0;
      r <= '0;
      flags <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        op_q <= op;
        bz_q <= b == '0;
      end
      if ((take && !iter_op) || done) begin
        r <= res_n;
        flags <= fl_n;
      end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors checked against a behavioural ALU model and literal expectations
module tb_alu_mc;
  typedef struct packed {logic [15:0] r; logic z, n, c, v, dz;} exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [3:0] op = 0;
  logic [15:0] a = 0, b = 0, r;
  logic flag_z, flag_n, flag_c, flag_v, flag_dz;
  int total = 0, bad = 0, cyc = 0;
  exp_t exp_q[$];
  int due_q[$];
  bit seen = 0;

  alu_mc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int sx, sy, s;
    longint p;
    e = '0;
    sx = $signed(x);
    sy = $signed(y);
    p = longint'(x) * longint'(y);
    case (o)
      4'h0: begin s = int'(x) + int'(y); e.r = 16'(s); e.c = s > 65535; e.v = (sx + sy) > 32767 || (sx + sy) < -32768; end
      4'h1: e.r = x | y;
      4'h2: e.r = x ^ y;
      4'h3: e.r = x & y;
      4'h4: e.r = y >= 16 ? 16'h0 : 16'(longint'(x) * (longint'(1) << y));
      4'h5: e.r = y >= 16 ? 16'h0 : 16'(int'(x) / (1 << y));
      4'h6: begin s = sx >>> ((y > 15) ? 15 : int'(y)); e.r = 16'(s); end
      4'h7: begin s = int'(x) - int'(y); e.r = 16'(s); e.c = s < 0; e.v = (sx - sy) > 32767 || (sx - sy) < -32768; end
      4'h8: e.r = p[15:0];
      4'h9: e.r = p[31:16];
      4'hA: begin e.r = y == 0 ? 16'hFFFF : x / y; e.dz = y == 0; end
      4'hB: begin e.r = y == 0 ? x : x % y; e.dz = y == 0; end
      4'hC: e.r = 16'(x == y);
      4'hD: e.r = 16'(x < y);
      4'hE: e.r = 16'(x > y);
      default: e.r = 16'h1;
    endcase
    e.z = e.r == 0;
    e.n = e.r[15];
    return e;
  endfunction

  // scoreboard: one compare point per falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      seen = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          if (!seen) chk("latency", cyc, due_q[0]);
          seen = 1;
          chk("result", r, exp_q[0].r);
          chk("flags", {flag_z, flag_n, flag_c, flag_v, flag_dz},
              {exp_q[0].z, exp_q[0].n, exp_q[0].c, exp_q[0].v, exp_q[0].dz});
          chk("ready_in_done", in_ready, out_ready);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            seen = 0;
          end
        end
      end else begin
        chk("ready_idle_busy", in_ready, exp_q.size() == 0);
        if (exp_q.size() != 0 && cyc >= due_q[0]) chk("late_valid", out_valid, 1);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(op, a, b));
        due_q.push_back(cyc + ((op >= 8 && op <= 11) ? 17 : 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int n = 0;
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    tick();
    in_valid = 0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", out_valid, 1);
  endtask

  task automatic run(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] want, input string nm);
    send(o, x, y);
    wait_valid();
    chk(nm, r, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    e = model(4'h0, 16'h7FFF, 16'h0001);
    chk("model_add", {e.r, e.n, e.v, e.c}, {16'h8000, 3'b110});
    e = model(4'h9, 16'h1234, 16'h5678);
    chk("model_mul_hi", e.r, 16'h0626);
    e = model(4'hB, 16'h1234, 16'h0000);
    chk("model_remu0", {e.r, e.dz}, {16'h1234, 1'b1});
    e = model(4'h6, 16'h8000, 16'd20);
    chk("model_sar", e.r, 16'hFFFF);
    repeat (2) @(negedge clk);
    chk("rst_r", r, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v, flag_dz}, 0);
    tick();
    rst_n = 1;
    run(4'h0, 16'h7FFF, 16'h0001, 16'h8000, "add");
    chk("add_nvc", {flag_n, flag_v, flag_c}, 3'b110);
    tick();
    run(4'h7, 16'h0003, 16'h0005, 16'hFFFE, "sub");
    chk("sub_borrow", flag_c, 1);
    tick();
    run(4'h6, 16'h8000, 16'd20, 16'hFFFF, "sar_big");
    tick();
    run(4'h4, 16'h00FF, 16'd16, 16'h0000, "shl_big");
    chk("shl_z", flag_z, 1);
    tick();
    run(4'h5, 16'h8000, 16'd15, 16'h0001, "shr15");
    tick();
    run(4'h8, 16'h1234, 16'h5678, 16'h0060, "mul_lo");
    tick();
    run(4'h9, 16'h1234, 16'h5678, 16'h0626, "mul_hi");
    tick();
    run(4'hA, 16'd100, 16'd7, 16'd14, "divu");
    tick();
    run(4'hB, 16'd100, 16'd7, 16'd2, "remu");
    tick();
    run(4'hA, 16'h1234, 16'h0000, 16'hFFFF, "divu0");
    chk("divu0_dz", flag_dz, 1);
    tick();
    run(4'hB, 16'h1234, 16'h0000, 16'h1234, "remu0");
    chk("remu0_dz", flag_dz, 1);
    tick();
    out_ready = 0;
    run(4'h1, 16'h00F0, 16'h0F00, 16'h0FF0, "or_hold");
    repeat (3) @(negedge clk);
    chk("hold_r", r, 16'h0FF0);
    chk("hold_valid", out_valid, 1);
    tick();
    out_ready = 1;
    run(4'h2, 16'hF0F0, 16'hFFFF, 16'h0F0F, "xor_accept");
    tick();
    send(4'h3, 16'hFF00, 16'h0FF0);
    send(4'hC, 16'h5555, 16'h5555);
    send(4'hE, 16'h0009, 16'h0003);
    send(4'hF, 16'h0000, 16'h0000);
    send(4'h0, 16'hFFFF, 16'h0001);
    repeat (3) tick();
    out_ready = 0;
    run(4'h0, 16'h0001, 16'h0001, 16'h0002, "add_pre_rst");
    tick();
    rst_n = 0;
    #1 chk("rst_in_done_valid", out_valid, 0);
    tick();
    rst_n = 1;
    out_ready = 1;
    send(4'hA, 16'd100, 16'd7);
    repeat (4) tick();
    rst_n = 0;
    #1 chk("rst_in_busy_valid", out_valid, 0);
    chk("rst_in_busy_ready", in_ready, 1);
    tick();
    rst_n = 1;
    run(4'hD, 16'd3, 16'd5, 16'h0001, "ltu_after_rst");
    repeat (20) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the LITE-16 core and its wider derivatives. It executes the single-cycle integer operations (add/sub/logic/shift/compare) in one cycle, and unsigned multiply/divide iteratively over WIDTH cycles. Results and flags are presented behind a valid/ready handshake so the execute stage can stall on long operations. It replaces the purely combinational ALU wherever multiply/divide or flag generation is required.

## Interface
- WIDTH, 16: datapath width; power of two, ≥ 8. SHW = log2(WIDTH) is derived, not a parameter.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- op  in  4  operation code (see Operation).
- a, b  in  WIDTH  operands, captured on transfer.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- r  out  WIDTH  result.
- flag_z, flag_n, flag_c, flag_v, flag_dz  out  1 each  zero, negative, carry/borrow, signed overflow, divide-by-zero.

## Operation
- Op codes: 0 add, 1 or, 2 xor, 3 and, 4 shl, 5 shr (logical), 6 sar (arithmetic), 7 sub (a−b), 8 mul_lo, 9 mul_hi, A divu (quotient), B remu, C cmp_eq, D cmp_ltu, E cmp_gtu, F cmp_always.
- Shifts: amount = full unsigned b. If b ≥ WIDTH: shl/shr → 0, sar → all copies of a[WIDTH-1].
- Compares: r = {0…, result}; cmp_always gives r = 1.
- mul: unsigned shift-add producing a 2·WIDTH product; mul_lo returns the low half, mul_hi the high half.
- divu/remu: unsigned restoring division, one quotient bit per cycle. If b = 0: quotient = all ones, remainder = a, flag_dz = 1, and the full WIDTH cycles are still spent.
- Flags are registered with r and valid while out_valid:
  - flag_z = (r == 0); flag_n = r[WIDTH-1].
  - flag_c = carry-out for add, borrow (a <u b) for sub, 0 otherwise.
  - flag_v = signed overflow for add/sub, 0 otherwise.
  - flag_dz as above, 0 for other ops.
- FSM states:
  - IDLE: in_ready = 1. On transfer, a single-cycle op → DONE; an iterative op → BUSY with cnt = 0.
  - BUSY: in_ready = 0. One step per cycle; cnt increments; on the step with cnt = WIDTH−1 → DONE.
  - DONE: out_valid = 1; r and flags held stable.
    - out_ready && !in_valid → IDLE.
    - out_ready && in_valid → accept the new op in the same cycle; go to DONE (single-cycle op) or BUSY (iterative op).
    - !out_ready → stay in DONE; in_ready = 0.
- in_ready = (state == IDLE) || (state == DONE && out_ready). Combinational; no path from in_valid.

## Timing
- Reset values: state IDLE, out_valid 0, r 0, all flags 0, cnt 0. in_ready = 1 as soon as reset is asserted.
- Single-cycle op accepted at edge k → out_valid high after edge k (visible in cycle k+1): latency 1.
- Iterative op accepted at edge k → out_valid high after edge k+WIDTH: latency WIDTH (16 for WIDTH = 16).
- Back-to-back single-cycle ops with out_ready held high sustain one result per cycle.
- Reset asserted mid-BUSY or in DONE: the operation is discarded immediately, out_valid drops asynchronously, and no stale result appears after release.
- Operand changes after the transfer have no effect.

## Structure
- Shared package lite16_alu_pkg holds:
  - op code constants;
  - FSM state encoding;
  - flag bit indices.
- One sub-module, alu_mc_iter, holds the iterative datapath: product/remainder accumulator (2·WIDTH), quotient shift register, step counter and start/done pulses. The top level keeps the FSM, single-cycle datapath, flag logic and output registers.

## Test plan
- add 0x7FFF + 0x0001 → r = 0x8000, flag_n = 1, flag_v = 1, flag_c = 0; out_valid one cycle after transfer. sub 0x0003 − 0x0005 → r = 0xFFFE, flag_c = 1.
- sar 0x8000 by b = 20 → r = 0xFFFF; shl 0x00FF by 16 → r = 0, flag_z = 1; shr 0x8000 by 15 → r = 0x0001.
- mul_lo 0x1234 × 0x5678 → r = 0x0060; mul_hi of the same operands → r = 0x0626. out_valid exactly 16 cycles after transfer; in_ready = 0 throughout BUSY.
- divu 100 / 7 → r = 14; remu → r = 2. divu 0x1234 / 0 → r = 0xFFFF, flag_dz = 1; remu 0x1234 / 0 → r = 0x1234.
- Backpressure: hold out_ready = 0 for 3 cycles → out_valid, r and flags stable. Then raise out_ready with in_valid (xor 0xF0F0, 0xFFFF) in the same cycle → accepted; next cycle r = 0x0F0F.
- Deassert rst_n at BUSY cycle 5 of a divu → out_valid = 0 immediately. After release, in_ready = 1, and cmp_ltu 3, 5 → r = 0x0001 after 1 cycle.
